// File: rtl/reorder_buffer_pq.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer_pq
// Purpose  : In-order commit ROB with NUM_WB writeback channels and two
//            combinational operand-query ports. Optional perf counters are
//            enabled by defining ROB_PERF_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module reorder_buffer_pq #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int NUM_WB = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    if_ins_launch_flag,
  input  logic [31:0]             if_ins,
  input  logic [31:0]             if_ins_pc,
  output logic                    rob_full,
  output logic                    new_ins_flag,
  output logic [31:0]             new_ins,
  output logic [TAG_W-1:0]        rename,
  output logic [4:0]              rename_reg,
  output logic                    new_ls_ins_flag,
  output logic [TAG_W-1:0]        new_ls_ins_rnm,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*TAG_W-1:0] wb_tag,
  input  logic [NUM_WB*32-1:0]    wb_value,
  input  logic [TAG_W-1:0]        qry_tag1,
  input  logic [TAG_W-1:0]        qry_tag2,
  output logic                    qry_ready1,
  output logic                    qry_ready2,
  output logic [31:0]             qry_value1,
  output logic [31:0]             qry_value2,
  input  logic                    rob_flush,
  output logic                    commit_flag,
  output logic [TAG_W-1:0]        commit_rename,
  output logic [31:0]             commit_value,
  output logic [4:0]              commit_dest,
  output logic                    commit_is_branch,
  output logic                    commit_is_jalr,
  output logic                    commit_is_store,
  output logic [31:0]             jalr_next_pc
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]             perf_commit_cnt,
  output logic [31:0]             perf_full_stall_cnt
`endif
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic       STATUS_ISSUE = 1'b0;
  localparam logic       STATUS_WRITE = 1'b1;
  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]         count_q, count_d;
  logic [DEPTH-1:0]       busy_q, busy_d, status_q, status_d;
  logic [DEPTH-1:0]       is_branch_q, is_branch_d, is_jalr_q, is_jalr_d, is_store_q, is_store_d;
  logic [DEPTH-1:0][4:0]  dest_q, dest_d;
  logic [DEPTH-1:0][31:0] value_q, value_d;

  logic             new_ins_flag_q, new_ins_flag_d, new_ls_ins_flag_q, new_ls_ins_flag_d;
  logic [31:0]      new_ins_q, new_ins_d;
  logic [TAG_W-1:0] rename_q, rename_d, new_ls_ins_rnm_q, new_ls_ins_rnm_d;
  logic [4:0]       rename_reg_q, rename_reg_d;
  logic             commit_flag_q, commit_flag_d;
  logic [TAG_W-1:0] commit_rename_q, commit_rename_d;
  logic [31:0]      commit_value_q, commit_value_d;
  logic [4:0]       commit_dest_q, commit_dest_d;
  logic             commit_is_branch_q, commit_is_branch_d;
  logic             commit_is_jalr_q, commit_is_jalr_d;
  logic             commit_is_store_q, commit_is_store_d;
  logic [31:0]      jalr_next_pc_q, jalr_next_pc_d;

  logic [6:0]  w_opcode;
  logic        w_issue_acc, w_commit_go;
  logic [32:0] w_qry1, w_qry2;

  assign w_opcode    = if_ins[6:0];
  assign rob_full    = (count_q == FULL_CNT);
  assign w_issue_acc = if_ins_launch_flag && !rob_full;
  assign w_commit_go = (count_q != '0) && (status_q[head_q] == STATUS_WRITE);

  // Writeback bypass: later channels override earlier ones on a shared tag.
  function automatic logic [32:0] query(input logic [TAG_W-1:0] tag);
    logic        hit;
    logic [31:0] val;
    hit = status_q[tag];
    val = value_q[tag];
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb_valid[i] && (wb_tag[i*TAG_W +: TAG_W] == tag)) begin
        hit = 1'b1;
        val = wb_value[i*32 +: 32];
      end
    end
    if (!busy_q[tag]) begin
      hit = 1'b0;
      val = '0;
    end
    return {hit, val};
  endfunction

  always_comb begin
    w_qry1 = query(qry_tag1);
    w_qry2 = query(qry_tag2);
  end

  assign qry_ready1 = w_qry1[32];
  assign qry_value1 = w_qry1[31:0];
  assign qry_ready2 = w_qry2[32];
  assign qry_value2 = w_qry2[31:0];

  always_comb begin
    head_d = head_q; tail_d = tail_q; count_d = count_q;
    busy_d = busy_q; status_d = status_q; dest_d = dest_q; value_d = value_q;
    is_branch_d = is_branch_q; is_jalr_d = is_jalr_q; is_store_d = is_store_q;
    new_ins_flag_d = 1'b0; new_ins_d = new_ins_q; rename_d = rename_q; rename_reg_d = rename_reg_q;
    new_ls_ins_flag_d = 1'b0; new_ls_ins_rnm_d = new_ls_ins_rnm_q;
    commit_flag_d = 1'b0; commit_rename_d = commit_rename_q; commit_value_d = commit_value_q;
    commit_dest_d = commit_dest_q; commit_is_branch_d = commit_is_branch_q;
    commit_is_jalr_d = commit_is_jalr_q; commit_is_store_d = commit_is_store_q;
    jalr_next_pc_d = jalr_next_pc_q;
    if (rob_flush) begin
      // Same as reset, except the JALR return address survives.
      head_d = '0; tail_d = '0; count_d = '0; busy_d = '0;
      new_ins_d = '0; rename_d = '0; rename_reg_d = '0; new_ls_ins_rnm_d = '0;
      commit_rename_d = '0; commit_value_d = '0; commit_dest_d = '0;
      commit_is_branch_d = 1'b0; commit_is_jalr_d = 1'b0; commit_is_store_d = 1'b0;
    end else begin
      if (w_issue_acc) begin
        busy_d[tail_q]      = 1'b1;
        dest_d[tail_q]      = if_ins[11:7];
        is_branch_d[tail_q] = (w_opcode == OP_BRANCH);
        is_jalr_d[tail_q]   = (w_opcode == OP_JALR);
        is_store_d[tail_q]  = (w_opcode == OP_STORE);
        status_d[tail_q]    = STATUS_ISSUE;
        value_d[tail_q]     = '0;
        case (w_opcode)
          OP_LUI:   begin status_d[tail_q] = STATUS_WRITE; value_d[tail_q] = {if_ins[31:12], 12'b0}; end
          OP_JAL:   begin status_d[tail_q] = STATUS_WRITE; value_d[tail_q] = if_ins_pc + 32'd4; end
          OP_AUIPC: begin status_d[tail_q] = STATUS_WRITE; value_d[tail_q] = {if_ins[31:12], 12'b0} + if_ins_pc; end
          OP_JALR:  jalr_next_pc_d = if_ins_pc + 32'd4;
          default:  ;
        endcase
        new_ins_flag_d = 1'b1;
        new_ins_d      = if_ins;
        rename_d       = tail_q;
        rename_reg_d   = if_ins[11:7];
        if ((w_opcode == OP_LOAD) || (w_opcode == OP_STORE)) begin
          new_ls_ins_flag_d = 1'b1;
          new_ls_ins_rnm_d  = tail_q;
        end
        tail_d = tail_q + TAG_W'(1);
      end
      for (int i = 0; i < NUM_WB; i++) begin
        if (wb_valid[i] && busy_q[wb_tag[i*TAG_W +: TAG_W]]) begin
          status_d[wb_tag[i*TAG_W +: TAG_W]] = STATUS_WRITE;
          value_d[wb_tag[i*TAG_W +: TAG_W]]  = wb_value[i*32 +: 32];
        end
      end
      if (w_commit_go) begin
        commit_flag_d      = 1'b1;
        commit_rename_d    = head_q;
        commit_value_d     = value_q[head_q];
        commit_dest_d      = dest_q[head_q];
        commit_is_branch_d = is_branch_q[head_q];
        commit_is_jalr_d   = is_jalr_q[head_q];
        commit_is_store_d  = is_store_q[head_q];
        busy_d[head_q]     = 1'b0;
        head_d             = head_q + TAG_W'(1);
      end
      count_d = count_q + (TAG_W+1)'(w_issue_acc) - (TAG_W+1)'(w_commit_go);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0; tail_q <= '0; count_q <= '0;
      busy_q <= '0; status_q <= '0; dest_q <= '0; value_q <= '0;
      is_branch_q <= '0; is_jalr_q <= '0; is_store_q <= '0;
      new_ins_flag_q <= 1'b0; new_ins_q <= '0; rename_q <= '0; rename_reg_q <= '0;
      new_ls_ins_flag_q <= 1'b0; new_ls_ins_rnm_q <= '0;
      commit_flag_q <= 1'b0; commit_rename_q <= '0; commit_value_q <= '0; commit_dest_q <= '0;
      commit_is_branch_q <= 1'b0; commit_is_jalr_q <= 1'b0; commit_is_store_q <= 1'b0;
      jalr_next_pc_q <= '0;
    end else if (rdy) begin
      head_q <= head_d; tail_q <= tail_d; count_q <= count_d;
      busy_q <= busy_d; status_q <= status_d; dest_q <= dest_d; value_q <= value_d;
      is_branch_q <= is_branch_d; is_jalr_q <= is_jalr_d; is_store_q <= is_store_d;
      new_ins_flag_q <= new_ins_flag_d; new_ins_q <= new_ins_d; rename_q <= rename_d;
      rename_reg_q <= rename_reg_d;
      new_ls_ins_flag_q <= new_ls_ins_flag_d; new_ls_ins_rnm_q <= new_ls_ins_rnm_d;
      commit_flag_q <= commit_flag_d; commit_rename_q <= commit_rename_d;
      commit_value_q <= commit_value_d; commit_dest_q <= commit_dest_d;
      commit_is_branch_q <= commit_is_branch_d; commit_is_jalr_q <= commit_is_jalr_d;
      commit_is_store_q <= commit_is_store_d;
      jalr_next_pc_q <= jalr_next_pc_d;
    end
  end

  assign new_ins_flag     = new_ins_flag_q;
  assign new_ins          = new_ins_q;
  assign rename           = rename_q;
  assign rename_reg       = rename_reg_q;
  assign new_ls_ins_flag  = new_ls_ins_flag_q;
  assign new_ls_ins_rnm   = new_ls_ins_rnm_q;
  assign commit_flag      = commit_flag_q;
  assign commit_rename    = commit_rename_q;
  assign commit_value     = commit_value_q;
  assign commit_dest      = commit_dest_q;
  assign commit_is_branch = commit_is_branch_q;
  assign commit_is_jalr   = commit_is_jalr_q;
  assign commit_is_store  = commit_is_store_q;
  assign jalr_next_pc     = jalr_next_pc_q;

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_commit_cnt_q, perf_commit_cnt_d;
  logic [31:0] perf_full_stall_cnt_q, perf_full_stall_cnt_d;

  // Flush does not clear these; only reset does.
  always_comb begin
    perf_commit_cnt_d     = perf_commit_cnt_q + 32'(w_commit_go && !rob_flush);
    perf_full_stall_cnt_d = perf_full_stall_cnt_q + 32'(if_ins_launch_flag && rob_full);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_commit_cnt_q     <= '0;
      perf_full_stall_cnt_q <= '0;
    end else if (rdy) begin
      perf_commit_cnt_q     <= perf_commit_cnt_d;
      perf_full_stall_cnt_q <= perf_full_stall_cnt_d;
    end
  end

  assign perf_commit_cnt     = perf_commit_cnt_q;
  assign perf_full_stall_cnt = perf_full_stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer_pq.sv
`default_nettype none
// ============================================================================
// Module   : tb_reorder_buffer_pq
// Purpose  : Scoreboard bench for reorder_buffer_pq (program-order tag queue
//            plus a per-entry reference model).
// Revision : 1.0  initial release
// ============================================================================
module tb_reorder_buffer_pq;

  localparam int DEPTH = 16, TAG_W = 4, NUM_WB = 4;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_ALU = 7'b0010011;

  logic clk = 1'b0;
  logic rst, rdy, if_ins_launch_flag, rob_flush;
  logic [31:0] if_ins, if_ins_pc;
  logic rob_full, new_ins_flag, new_ls_ins_flag, commit_flag;
  logic [31:0] new_ins, commit_value, jalr_next_pc, qry_value1, qry_value2;
  logic [TAG_W-1:0] rename, new_ls_ins_rnm, commit_rename, qry_tag1, qry_tag2;
  logic [4:0] rename_reg, commit_dest;
  logic [NUM_WB-1:0] wb_valid;
  logic [NUM_WB*TAG_W-1:0] wb_tag;
  logic [NUM_WB*32-1:0] wb_value;
  logic qry_ready1, qry_ready2, commit_is_branch, commit_is_jalr, commit_is_store;
`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_commit_cnt, perf_full_stall_cnt;
`endif

  reorder_buffer_pq #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_WB(NUM_WB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_ins_launch_flag(if_ins_launch_flag), .if_ins(if_ins), .if_ins_pc(if_ins_pc),
    .rob_full(rob_full), .new_ins_flag(new_ins_flag), .new_ins(new_ins),
    .rename(rename), .rename_reg(rename_reg),
    .new_ls_ins_flag(new_ls_ins_flag), .new_ls_ins_rnm(new_ls_ins_rnm),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .qry_tag1(qry_tag1), .qry_tag2(qry_tag2),
    .qry_ready1(qry_ready1), .qry_ready2(qry_ready2),
    .qry_value1(qry_value1), .qry_value2(qry_value2),
    .rob_flush(rob_flush), .commit_flag(commit_flag), .commit_rename(commit_rename),
    .commit_value(commit_value), .commit_dest(commit_dest),
    .commit_is_branch(commit_is_branch), .commit_is_jalr(commit_is_jalr),
    .commit_is_store(commit_is_store), .jalr_next_pc(jalr_next_pc)
`ifdef ROB_PERF_CNT_EN
    , .perf_commit_cnt(perf_commit_cnt), .perf_full_stall_cnt(perf_full_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int sb[$];
  logic [31:0] m_val[DEPTH];
  logic [4:0]  m_dest[DEPTH];
  bit m_wr[DEPTH], m_busy[DEPTH], m_br[DEPTH], m_jr[DEPTH], m_st[DEPTH];
  int m_tail = 0;
  bit e_c, e_i, e_ls, e_cb, e_cj, e_cs;
  int e_ct, e_it;
  logic [31:0] e_cv, e_jpc;
  logic [4:0] e_cd, e_ird;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one clock: update the reference model from current inputs, then compare.
  task automatic step();
    logic [6:0] op;
    if (rdy) begin
      e_c = 0; e_i = 0; e_ls = 0;
      if (!rob_flush) begin
        op = if_ins[6:0];
        if (sb.size() != 0 && m_wr[sb[0]]) begin
          e_c = 1; e_ct = sb[0]; e_cv = m_val[e_ct]; e_cd = m_dest[e_ct];
          e_cb = m_br[e_ct]; e_cj = m_jr[e_ct]; e_cs = m_st[e_ct];
        end
        e_i = if_ins_launch_flag && (sb.size() < DEPTH);
        for (int ch = 0; ch < NUM_WB; ch++) begin
          int t;
          t = int'(wb_tag[ch*TAG_W +: TAG_W]);
          if (wb_valid[ch] && m_busy[t]) begin
            m_wr[t] = 1; m_val[t] = wb_value[ch*32 +: 32];
          end
        end
        if (e_c) begin
          void'(sb.pop_front());
          m_busy[e_ct] = 0;
        end
        if (e_i) begin
          e_it = m_tail; e_ird = if_ins[11:7];
          e_ls = (op == OP_LD) || (op == OP_ST);
          m_busy[m_tail] = 1; m_dest[m_tail] = if_ins[11:7];
          m_br[m_tail] = (op == OP_BR); m_jr[m_tail] = (op == OP_JALR); m_st[m_tail] = (op == OP_ST);
          m_wr[m_tail] = (op == OP_LUI) || (op == OP_JAL) || (op == OP_AUIPC);
          m_val[m_tail] = (op == OP_LUI)   ? {if_ins[31:12], 12'b0} :
                          (op == OP_JAL)   ? if_ins_pc + 32'd4 :
                          (op == OP_AUIPC) ? {if_ins[31:12], 12'b0} + if_ins_pc : 32'd0;
          if (op == OP_JALR) e_jpc = if_ins_pc + 32'd4;
          sb.push_back(m_tail);
          m_tail = (m_tail + 1) % DEPTH;
        end
      end else begin
        sb.delete();
        for (int k = 0; k < DEPTH; k++) m_busy[k] = 0;
        m_tail = 0;
      end
    end
    @(posedge clk); #1;
    check("commit_flag", commit_flag, e_c);
    if (e_c) begin
      check("commit_rename", commit_rename, e_ct);
      check("commit_value", commit_value, e_cv);
      check("commit_dest", commit_dest, e_cd);
      check("commit_class", {commit_is_branch, commit_is_jalr, commit_is_store}, {e_cb, e_cj, e_cs});
    end
    check("new_ins_flag", new_ins_flag, e_i);
    if (e_i) begin
      check("rename", rename, e_it);
      check("rename_reg", rename_reg, e_ird);
    end
    check("new_ls_ins_flag", new_ls_ins_flag, e_ls);
    if (e_ls) check("new_ls_ins_rnm", new_ls_ins_rnm, e_it);
    check("rob_full", rob_full, sb.size() == DEPTH);
    check("jalr_next_pc", jalr_next_pc, e_jpc);
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, op};
  endfunction

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    if_ins_launch_flag = 1; if_ins = ins; if_ins_pc = pc;
    step();
    if_ins_launch_flag = 0;
  endtask

  task automatic wb1(input int ch, input int tag, input logic [31:0] val);
    wb_valid[ch] = 1; wb_tag[ch*TAG_W +: TAG_W] = TAG_W'(tag); wb_value[ch*32 +: 32] = val;
    step();
    wb_valid = '0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 64) begin
      step();
      guard++;
    end
    if (guard >= 64) check("drain_timeout", 32'd1, 32'd0);
    step();
  endtask

  task automatic flush();
    rob_flush = 1; step(); rob_flush = 0;
  endtask

  initial begin
    int pend[$];
    rst = 1; rdy = 1; if_ins_launch_flag = 0; if_ins = '0; if_ins_pc = '0;
    wb_valid = '0; wb_tag = '0; wb_value = '0; qry_tag1 = '0; qry_tag2 = '0; rob_flush = 0;
    e_c = 0; e_i = 0; e_ls = 0; e_jpc = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_commit_flag", commit_flag, 0);
    check("rst_new_ins_flag", new_ins_flag, 0);
    check("rst_new_ls_flag", new_ls_ins_flag, 0);
    check("rst_rob_full", rob_full, 0);
    check("rst_jalr_pc", jalr_next_pc, 0);
    check("rst_qry_ready", qry_ready1, 0);
    rst = 0;

    // Single ALU op, writeback on channel 1.
    issue(mk(OP_ALU, 5'd3, 20'h00100), 32'h0);
    wb1(1, 0, 32'h55);
    step();

    // Fill to full with a mix of classes, then overflow request.
    for (int i = 0; i < DEPTH; i++) begin
      case (i % 4)
        1: issue(mk(OP_LD, 5'(i), 20'h00002), 32'(i * 4));
        2: issue(mk(OP_ST, 5'(i), 20'h00002), 32'(i * 4));
        3: issue(mk(OP_BR, 5'(i), 20'h00000), 32'(i * 4));
        default: issue(mk(OP_ALU, 5'(i), 20'h00100), 32'(i * 4));
      endcase
    end
    check("full_after_fill", rob_full, 1);
    issue(mk(OP_ALU, 5'd9, 20'h0), 32'h100);
    wb1(0, sb[0], 32'hA0);
    step();
    issue(mk(OP_ALU, 5'd10, 20'h0), 32'h104);
    // Reverse-order writebacks, two channels per cycle; commits stay in order.
    pend = sb;
    for (int k = pend.size() - 1; k >= 0; k -= 2) begin
      wb_valid[0] = 1; wb_tag[0 +: TAG_W] = TAG_W'(pend[k]); wb_value[0 +: 32] = 32'(pend[k] * 17);
      if (k >= 1) begin
        wb_valid[2] = 1; wb_tag[2*TAG_W +: TAG_W] = TAG_W'(pend[k-1]);
        wb_value[64 +: 32] = 32'(pend[k-1] * 31);
      end
      step();
      wb_valid = '0;
    end
    drain();

    // Issue-complete classes and JALR return address.
    issue(mk(OP_LUI, 5'd5, 20'h12345), 32'h0);
    issue(mk(OP_JAL, 5'd1, 20'h00000), 32'h100);
    issue(mk(OP_AUIPC, 5'd2, 20'h00001), 32'h200);
    issue(mk(OP_JALR, 5'd1, 20'h00000), 32'h300);
    wb1(3, sb[sb.size()-1], 32'h0);
    drain();

    // Flush, then a writeback to an empty slot must be ignored.
    flush();
    wb1(0, 0, 32'hDEAD);
    issue(mk(OP_ALU, 5'd7, 20'h0), 32'h0);
    step(); step();
    issue(mk(OP_ALU, 5'd8, 20'h0), 32'h4);
    issue(mk(OP_ALU, 5'd9, 20'h0), 32'h8);
    issue(mk(OP_ALU, 5'd11, 20'h0), 32'hC);
    wb1(0, 0, 32'h10);
    wb1(1, 1, 32'h11);
    wb1(2, 3, 32'h33);
    wb1(2, 2, 32'h22);
    drain();

    // Duplicate-tag writeback and query bypass.
    flush();
    issue(mk(OP_ALU, 5'd1, 20'h0), 32'h0);
    issue(mk(OP_ALU, 5'd2, 20'h0), 32'h4);
    issue(mk(OP_ALU, 5'd3, 20'h0), 32'h8);
    wb_valid = 4'b1001; wb_tag[0 +: TAG_W] = 4'd2; wb_tag[3*TAG_W +: TAG_W] = 4'd2;
    wb_value[0 +: 32] = 32'h11; wb_value[96 +: 32] = 32'h22;
    qry_tag1 = 4'd2; qry_tag2 = 4'd5;
    #1;
    check("qry_ready1_bypass", qry_ready1, 1);
    check("qry_value1_bypass", qry_value1, 32'h22);
    check("qry_ready2_nonbusy", qry_ready2, 0);
    check("qry_value2_nonbusy", qry_value2, 0);
    qry_tag2 = 4'd0;
    #1;
    check("qry_ready2_issue", qry_ready2, 0);
    step();
    wb_valid = '0;
    #1;
    check("qry_ready1_state", qry_ready1, 1);
    check("qry_value1_state", qry_value1, 32'h22);
    wb1(0, 0, 32'h1);
    wb1(1, 1, 32'h2);
    drain();

    // Flush beats simultaneous issue, writeback and an eligible commit.
    issue(mk(OP_ALU, 5'd4, 20'h0), 32'h0);
    wb1(0, sb[0], 32'h77);
    if_ins_launch_flag = 1; if_ins = mk(OP_LD, 5'd6, 20'h0);
    wb_valid[1] = 1; wb_tag[TAG_W +: TAG_W] = TAG_W'(sb[0]); wb_value[32 +: 32] = 32'h99;
    flush();
    if_ins_launch_flag = 0; wb_valid = '0;
    check("flush_rob_full", rob_full, 0);
    issue(mk(OP_LD, 5'd6, 20'h0), 32'h40);

    // rdy low freezes everything, including the issue pulse.
    rdy = 0;
    if_ins_launch_flag = 1; if_ins = mk(OP_ALU, 5'd12, 20'h0);
    step(); step();
    if_ins_launch_flag = 0; rdy = 1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
